// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), one bit per clock,
// LSB first, using a single full-adder slice fed with the inverted subtrahend.
// The adder carry is the complement of the running borrow, so it starts at ~bin
// and the final borrow-out is the complement of the last carry.
// Handshake: start is taken only while ready=1; done pulses for one cycle when
// diff/bout are valid, and the results hold until the next accepted start.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             a_bit;
  logic             nb_bit;
  logic             sum_bit;
  logic             c_next;

  // Full-adder slice for the bit selected by the counter, subtrahend inverted.
  always_comb begin
    a_bit   = a_q[cnt];
    nb_bit  = ~b_q[cnt];
    sum_bit = a_bit ^ nb_bit ^ c;
    c_next  = (a_bit & nb_bit) | (a_bit & c) | (nb_bit & c);
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            c     <= ~bin;
            cnt   <= '0;
            ready <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          diff <= {sum_bit, diff[WIDTH-1:1]};
          c    <= c_next;
          if (cnt == LAST_BIT) begin
            cnt   <= '0;
            done  <= 1'b1;
            bout  <= ~c_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= c ^ c_next;
`endif
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Directed bench for serial_subtractor (WIDTH=8). Overflow checks are compiled
// in when SERIAL_SUB_OVF_EN is defined.

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             done;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .diff  (diff),
    .bout  (bout),
    .done  (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation: start is driven for the accepting edge only, operands
  // are scrambled right after it, and results are captured on the done cycle.
  // lat is the number of edges after the accepting edge at which done was seen
  // (-1 if never seen within the bound).
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tbin,
                        output logic [WIDTH-1:0] rdiff, output logic rbout,
                        output logic rovf, output logic rready,
                        output int lat, output int pulses);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb; bin = ~tbin;
    rready = ready;
    rdiff = '0; rbout = 1'b0; rovf = 1'b0;
    lat = -1; pulses = 0;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat   = k;
          rdiff = diff;
          rbout = bout;
`ifdef SERIAL_SUB_OVF_EN
          rovf  = ovf;
`else
          rovf  = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++;
    if (diff !== 8'h00) begin errors++; $display("[TB] FAIL reset_diff got %h want 00", diff); end
    checks++;
    if (bout !== 1'b0) begin errors++; $display("[TB] FAIL reset_bout got %b want 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_subtract(input string name, input logic [WIDTH-1:0] ta,
                               input logic [WIDTH-1:0] tb, input logic tbin,
                               input logic [WIDTH-1:0] ediff, input logic ebout,
                               input logic eovf);
    logic [WIDTH-1:0] rdiff;
    logic rbout, rovf, rready;
    int lat, pulses;
    run_op(ta, tb, tbin, rdiff, rbout, rovf, rready, lat, pulses);
    checks++;
    if (rready !== 1'b0) begin errors++; $display("[TB] FAIL %s_ready_busy got %b want 0", name, rready); end
    checks++;
    if (lat != WIDTH) begin errors++; $display("[TB] FAIL %s_latency got %0d want %0d", name, lat, WIDTH); end
    checks++;
    if (pulses != 1) begin errors++; $display("[TB] FAIL %s_done_pulses got %0d want 1", name, pulses); end
    checks++;
    if (rdiff !== ediff) begin errors++; $display("[TB] FAIL %s_diff got %h want %h", name, rdiff, ediff); end
    checks++;
    if (rbout !== ebout) begin errors++; $display("[TB] FAIL %s_bout got %b want %b", name, rbout, ebout); end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (rovf !== eovf) begin errors++; $display("[TB] FAIL %s_ovf got %b want %b", name, rovf, eovf); end
`else
    if (eovf === 1'bx) $display("[TB] note: unexpected x in %s", name);
`endif
    checks++;
    if (diff !== ediff) begin errors++; $display("[TB] FAIL %s_diff_hold got %h want %h", name, diff, ediff); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL %s_ready_idle got %b want 1", name, ready); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [WIDTH-1:0] first_diff;
    pulses = 0;
    first_diff = '0;
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= WIDTH + 1; k++) begin
      a = 8'h20 + 8'(k); b = 8'h01;
      if (k == WIDTH + 1) begin a = 8'h40; b = 8'h01; end
      @(negedge clk);
      if (done) begin pulses++; first_diff = diff; end
      if (k == WIDTH + 1) begin
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after_done got %b want 1", ready); end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("[TB] FAIL b2b_pulses got %0d want 1", pulses); end
    checks++;
    if (first_diff !== 8'h02) begin errors++; $display("[TB] FAIL b2b_first_diff got %h want 02", first_diff); end
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'h55;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_accept got %b want 0", ready); end
    pulses = 0;
    first_diff = '0;
    for (int k = 2; k <= WIDTH + 4; k++) begin
      @(negedge clk);
      if (done) begin pulses++; first_diff = diff; end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("[TB] FAIL b2b_second_pulses got %0d want 1", pulses); end
    checks++;
    if (first_diff !== 8'h3F) begin errors++; $display("[TB] FAIL b2b_second_diff got %h want 3f", first_diff); end
  endtask

  task automatic test_abort();
    int pulses;
    pulses = 0;
    @(negedge clk);
    a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready got %b want 1", ready); end
    checks++;
    if (diff !== 8'h00) begin errors++; $display("[TB] FAIL abort_diff got %h want 00", diff); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %b want 0", done); end
    checks++;
    if (bout !== 1'b0) begin errors++; $display("[TB] FAIL abort_bout got %b want 0", bout); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d want 0", pulses); end
    test_subtract("after_abort", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_subtract("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    test_subtract("negative", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    test_subtract("borrow_in", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    test_subtract("all_ones", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
    test_subtract("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    test_subtract("no_ovf", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);
    test_subtract("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
